// File: rtl/ro_deserializer.sv
// Readout-bus deserializer: decodes the gray-slotted slot owner and demultiplexes
// the eve / pol_eve bus lines into per-channel hold banks.
module ro_deserializer #(
    parameter int unsigned N_CH  = 19,
    parameter int unsigned IDX_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk_master,
    input  logic              reset,
    input  logic              en,
    input  logic [N_CH-1:0]   gray,
    input  logic              in_mux_eve,
    input  logic              in_mux_pol_eve,
    output logic              ch_valid,
    output logic [IDX_W-1:0]  ch_idx,
    output logic              ch_eve,
    output logic              ch_pol_eve,
    output logic [N_CH-1:0]   eve_bank,
    output logic [N_CH-1:0]   pol_bank,
    output logic [N_CH-1:0]   fresh_mask,
    output logic              frame_done,
    output logic [CNT_W-1:0]  ev_count,
    output logic              gray_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH-1:0]  gray_q, gray_d;
    logic             armed_q, armed_d;
    logic             ch_valid_q, ch_valid_d;
    logic [IDX_W-1:0] ch_idx_q, ch_idx_d;
    logic             ch_eve_q, ch_eve_d;
    logic             ch_pol_q, ch_pol_d;
    logic [N_CH-1:0]  eve_bank_q, eve_bank_d;
    logic [N_CH-1:0]  pol_bank_q, pol_bank_d;
    logic [N_CH-1:0]  fresh_q, fresh_d;
    logic             frame_q, frame_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [N_CH-1:0]  diff_c;
    logic             hit_c;
    logic             multi_c;
    logic [IDX_W-1:0] idx_c;

    // Classify the gray step: none, exactly one bit (with its index), or several bits.
    always_comb begin
        diff_c  = gray ^ gray_q;
        hit_c   = 1'b0;
        multi_c = 1'b0;
        idx_c   = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (diff_c[i]) begin
                if (hit_c) begin
                    multi_c = 1'b1;
                end
                hit_c = 1'b1;
                idx_c = IDX_W'(i);
            end
        end
    end

    // Next-state: arm/load, decode a legal step, flag illegal steps.
    always_comb begin
        gray_d     = gray_q;
        armed_d    = armed_q;
        ch_valid_d = 1'b0;
        ch_idx_d   = ch_idx_q;
        ch_eve_d   = ch_eve_q;
        ch_pol_d   = ch_pol_q;
        eve_bank_d = eve_bank_q;
        pol_bank_d = pol_bank_q;
        fresh_d    = fresh_q;
        frame_d    = 1'b0;
        cnt_d      = cnt_q;
        err_d      = err_q;

        if (!en) begin
            armed_d = 1'b0;
        end else if (!armed_q) begin
            // Load-only cycle: the previous gray value is not trustworthy yet.
            gray_d  = gray;
            armed_d = 1'b1;
        end else begin
            gray_d = gray;
            if (multi_c) begin
                err_d = 1'b1;
            end else if (hit_c) begin
                ch_valid_d = 1'b1;
                ch_idx_d   = idx_c;
                ch_eve_d   = in_mux_eve;
                ch_pol_d   = in_mux_pol_eve;
                eve_bank_d = (eve_bank_q & ~diff_c) | (diff_c & {N_CH{in_mux_eve}});
                pol_bank_d = (pol_bank_q & ~diff_c) | (diff_c & {N_CH{in_mux_pol_eve}});
                // Last channel closes the frame; its own bit survives the clear.
                if (diff_c[N_CH-1]) begin
                    frame_d = 1'b1;
                    fresh_d = diff_c;
                end else begin
                    fresh_d = fresh_q | diff_c;
                end
                if (in_mux_eve && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_master) begin
        if (reset) begin
            gray_q     <= '0;
            armed_q    <= 1'b0;
            ch_valid_q <= 1'b0;
            ch_idx_q   <= '0;
            ch_eve_q   <= 1'b0;
            ch_pol_q   <= 1'b0;
            eve_bank_q <= '0;
            pol_bank_q <= '0;
            fresh_q    <= '0;
            frame_q    <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            gray_q     <= gray_d;
            armed_q    <= armed_d;
            ch_valid_q <= ch_valid_d;
            ch_idx_q   <= ch_idx_d;
            ch_eve_q   <= ch_eve_d;
            ch_pol_q   <= ch_pol_d;
            eve_bank_q <= eve_bank_d;
            pol_bank_q <= pol_bank_d;
            fresh_q    <= fresh_d;
            frame_q    <= frame_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign ch_valid   = ch_valid_q;
    assign ch_idx     = ch_idx_q;
    assign ch_eve     = ch_eve_q;
    assign ch_pol_eve = ch_pol_q;
    assign eve_bank   = eve_bank_q;
    assign pol_bank   = pol_bank_q;
    assign fresh_mask = fresh_q;
    assign frame_done = frame_q;
    assign ev_count   = cnt_q;
    assign gray_err   = err_q;

endmodule

// File: tb/tb_ro_deserializer.sv
// Bench for ro_deserializer: directed vector table plus free-running and disable sequences.
module tb_ro_deserializer;

    localparam int unsigned N_CH  = 19;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned CNT_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [N_CH-1:0]   gray;
    logic              eve_i;
    logic              pol_i;
    logic              ch_valid;
    logic [IDX_W-1:0]  ch_idx;
    logic              ch_eve;
    logic              ch_pol_eve;
    logic [N_CH-1:0]   eve_bank;
    logic [N_CH-1:0]   pol_bank;
    logic [N_CH-1:0]   fresh_mask;
    logic              frame_done;
    logic [CNT_W-1:0]  ev_count;
    logic              gray_err;

    // Narrow-counter instance to exercise saturation cheaply.
    logic              s_valid;
    logic [IDX_W-1:0]  s_idx;
    logic              s_eve;
    logic              s_pol;
    logic [N_CH-1:0]   s_ebank;
    logic [N_CH-1:0]   s_pbank;
    logic [N_CH-1:0]   s_fresh;
    logic              s_frame;
    logic [2:0]        s_cnt;
    logic              s_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ro_deserializer #(.N_CH(N_CH), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_dut (
        .clk_master(clk), .reset(reset), .en(en), .gray(gray),
        .in_mux_eve(eve_i), .in_mux_pol_eve(pol_i),
        .ch_valid(ch_valid), .ch_idx(ch_idx), .ch_eve(ch_eve), .ch_pol_eve(ch_pol_eve),
        .eve_bank(eve_bank), .pol_bank(pol_bank), .fresh_mask(fresh_mask),
        .frame_done(frame_done), .ev_count(ev_count), .gray_err(gray_err)
    );

    ro_deserializer #(.N_CH(N_CH), .IDX_W(IDX_W), .CNT_W(3)) u_sat (
        .clk_master(clk), .reset(reset), .en(en), .gray(gray),
        .in_mux_eve(eve_i), .in_mux_pol_eve(pol_i),
        .ch_valid(s_valid), .ch_idx(s_idx), .ch_eve(s_eve), .ch_pol_eve(s_pol),
        .eve_bank(s_ebank), .pol_bank(s_pbank), .fresh_mask(s_fresh),
        .frame_done(s_frame), .ev_count(s_cnt), .gray_err(s_err)
    );

    typedef struct {
        logic             rst;
        logic             en;
        logic [N_CH-1:0]  gray;
        logic             eve;
        logic             pol;
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             frame;
        logic             err;
        logic [N_CH-1:0]  fresh;
        logic [N_CH-1:0]  ebank;
        logic [N_CH-1:0]  pbank;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic e, input int g, input logic ev, input logic pl,
                       input logic v, input int ix, input logic fr, input logic er,
                       input int fm, input int eb, input int pb, input int c);
        vec_t x;
        x.rst = rst; x.en = e; x.gray = N_CH'(g); x.eve = ev; x.pol = pl;
        x.valid = v; x.idx = IDX_W'(ix); x.frame = fr; x.err = er;
        x.fresh = N_CH'(fm); x.ebank = N_CH'(eb); x.pbank = N_CH'(pb); x.cnt = CNT_W'(c);
        vt.push_back(x);
    endtask

    task automatic drive(input logic rst, input logic e, input logic [N_CH-1:0] g,
                         input logic ev, input logic pl);
        @(negedge clk);
        reset = rst; en = e; gray = g; eve_i = ev; pol_i = pl;
        @(posedge clk);
        #1;
    endtask

    function automatic int tz(input int b);
        for (int k = 0; k < 32; k++) begin
            if (b[k]) return k;
        end
        return 0;
    endfunction

    function automatic logic [N_CH-1:0] to_gray(input int b);
        return N_CH'(b ^ (b >> 1));
    endfunction

    initial begin
        reset = 1'b1; en = 1'b0; gray = '0; eve_i = 1'b0; pol_i = 1'b0;

        //   rst en gray     eve pol | valid idx frame err fresh    ebank    pbank    cnt
        add(1, 0, 'h0,      0, 0,     0, 0,  0, 0, 'h0,     'h0,     'h0,     0);
        add(1, 0, 'h0,      0, 0,     0, 0,  0, 0, 'h0,     'h0,     'h0,     0);
        add(1, 0, 'h0,      0, 0,     0, 0,  0, 0, 'h0,     'h0,     'h0,     0);
        add(0, 1, 'h1,      1, 0,     0, 0,  0, 0, 'h0,     'h0,     'h0,     0);
        add(0, 1, 'h3,      1, 1,     1, 1,  0, 0, 'h2,     'h2,     'h2,     1);
        add(0, 1, 'h3,      0, 0,     0, 0,  0, 0, 'h2,     'h2,     'h2,     1);
        add(0, 1, 'h2,      0, 1,     1, 0,  0, 0, 'h3,     'h2,     'h3,     1);
        add(0, 1, 'h6,      1, 0,     1, 2,  0, 0, 'h7,     'h6,     'h3,     2);
        add(0, 1, 'h5,      1, 1,     0, 0,  0, 1, 'h7,     'h6,     'h3,     2);
        add(0, 1, 'h4,      1, 1,     1, 0,  0, 1, 'h7,     'h7,     'h3,     3);
        add(0, 1, 'h40004,  0, 1,     1, 18, 1, 1, 'h40000, 'h7,     'h40003, 3);
        add(0, 1, 'h40004,  0, 0,     0, 0,  0, 1, 'h40000, 'h7,     'h40003, 3);
        add(0, 0, 'h40005,  1, 1,     0, 0,  0, 1, 'h40000, 'h7,     'h40003, 3);
        add(0, 1, 'h40007,  1, 1,     0, 0,  0, 1, 'h40000, 'h7,     'h40003, 3);
        add(0, 1, 'h40006,  1, 0,     1, 0,  0, 1, 'h40001, 'h7,     'h40002, 4);
        add(1, 1, 'h40004,  1, 1,     0, 0,  0, 0, 'h0,     'h0,     'h0,     0);
        add(0, 1, 'h40005,  1, 1,     0, 0,  0, 0, 'h0,     'h0,     'h0,     0);
        add(0, 1, 'h40004,  1, 1,     1, 0,  0, 0, 'h1,     'h1,     'h1,     1);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].en, vt[i].gray, vt[i].eve, vt[i].pol);
            chk($sformatf("v%0d ch_valid", i), 32'(ch_valid), 32'(vt[i].valid));
            chk($sformatf("v%0d frame_done", i), 32'(frame_done), 32'(vt[i].frame));
            chk($sformatf("v%0d gray_err", i), 32'(gray_err), 32'(vt[i].err));
            chk($sformatf("v%0d fresh_mask", i), 32'(fresh_mask), 32'(vt[i].fresh));
            chk($sformatf("v%0d eve_bank", i), 32'(eve_bank), 32'(vt[i].ebank));
            chk($sformatf("v%0d pol_bank", i), 32'(pol_bank), 32'(vt[i].pbank));
            chk($sformatf("v%0d ev_count", i), 32'(ev_count), 32'(vt[i].cnt));
            if (vt[i].valid) begin
                chk($sformatf("v%0d ch_idx", i), 32'(ch_idx), 32'(vt[i].idx));
                chk($sformatf("v%0d ch_eve", i), 32'(ch_eve), 32'(vt[i].eve));
                chk($sformatf("v%0d ch_pol_eve", i), 32'(ch_pol_eve), 32'(vt[i].pol));
            end
        end

        // Free-running binary-reflected gray count, eve=pol=1.
        drive(1, 1, '0, 1, 1);
        for (int b = 0; b < 64; b++) begin
            drive(0, 1, to_gray(b), 1, 1);
            chk($sformatf("run b%0d ch_valid", b), 32'(ch_valid), (b == 0) ? 32'd0 : 32'd1);
            if (b != 0) chk($sformatf("run b%0d ch_idx", b), 32'(ch_idx), 32'(tz(b)));
        end
        chk("run ev_count", 32'(ev_count), 32'd63);
        chk("run gray_err", 32'(gray_err), 32'd0);
        chk("run eve_bank", 32'(eve_bank), 32'h3f);
        chk("run fresh_mask", 32'(fresh_mask), 32'h3f);
        chk("run sat_count", 32'(s_cnt), 32'd7);

        // Disable while the counter keeps advancing, then re-enable.
        for (int b = 64; b < 74; b++) begin
            drive(0, 0, to_gray(b), 1, 1);
            chk($sformatf("dis b%0d ch_valid", b), 32'(ch_valid), 32'd0);
        end
        drive(0, 1, to_gray(74), 0, 0);
        chk("reen load ch_valid", 32'(ch_valid), 32'd0);
        chk("reen eve_bank", 32'(eve_bank), 32'h3f);
        chk("reen pol_bank", 32'(pol_bank), 32'h3f);
        chk("reen ev_count", 32'(ev_count), 32'd63);
        chk("reen fresh_mask", 32'(fresh_mask), 32'h3f);
        drive(0, 1, to_gray(75), 1, 0);
        chk("reen step ch_valid", 32'(ch_valid), 32'd1);
        chk("reen step ch_idx", 32'(ch_idx), 32'd0);
        chk("reen step pol_bank", 32'(pol_bank), 32'h3e);
        chk("reen step ev_count", 32'(ev_count), 32'd64);
        drive(0, 1, to_gray(75), 1, 0);
        chk("pulse ch_valid", 32'(ch_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
